// File: rtl/mixer_lo_sequencer_if.sv
// Handshake and operand bundle between the front end, the LO sequencer and the complex mixer.
interface mixer_lo_sequencer_if #(
    parameter int unsigned PHASE_W = 16,
    parameter int unsigned DW      = 8
);
    logic               rf_valid;
    logic [DW-1:0]      rf_i_in;
    logic [DW-1:0]      rf_q_in;
    logic [PHASE_W-1:0] freq_word;
    logic               freq_valid;
    logic               freq_ready;
    logic               flush;
    logic               mixer_en;
    logic [DW-1:0]      rf_i;
    logic [DW-1:0]      rf_q;
    logic [DW-1:0]      lo_i;
    logic [DW-1:0]      lo_q;
    logic               if_valid;
    logic               busy;

    // Upstream side: presents samples, retune words and flush requests.
    modport master (
        output rf_valid, rf_i_in, rf_q_in, freq_word, freq_valid, flush,
        input  freq_ready, mixer_en, rf_i, rf_q, lo_i, lo_q, if_valid, busy
    );

    // Sequencer side.
    modport slave (
        input  rf_valid, rf_i_in, rf_q_in, freq_word, freq_valid, flush,
        output freq_ready, mixer_en, rf_i, rf_q, lo_i, lo_q, if_valid, busy
    );
endinterface

// File: rtl/mixer_lo_sequencer.sv
// LO source and sequencer for the complex mixer: primes the mixer after reset, feeds RF samples
// with a quadrature LO from a phase accumulator, flushes the last sample and flags valid IF output.
module mixer_lo_sequencer #(
    parameter int unsigned PHASE_W  = 16,
    parameter int unsigned TABLE_AW = 6,  // sine table below is fixed at 64 entries
    parameter int unsigned DW       = 8
) (
    input logic                 clock,
    input logic                 reset_n,
    mixer_lo_sequencer_if.slave bus_io
);

    typedef enum logic [1:0] {StPrime, StRun, StFlush} state_e;

    // Enables needed to clear the mixer's init cycle plus both pipeline registers.
    localparam logic [1:0] PrimeEnables = 2'd3;

    state_e              state_q;
    logic [1:0]          prime_cnt_q;
    logic [PHASE_W-1:0]  phase_q;
    logic [PHASE_W-1:0]  freq_q;
    logic                mixer_en_q;
    logic                en_tag_q;    // tag of the enable currently on mixer_en (1 = real sample)
    logic                tag_prev_q;  // tag of the enable before that
    logic                if_valid_q;
    logic [DW-1:0]       rf_i_q;
    logic [DW-1:0]       rf_q_q;
    logic [DW-1:0]       lo_i_q;
    logic [DW-1:0]       lo_q_q;

    logic [TABLE_AW-1:0] sin_idx;
    logic [TABLE_AW-1:0] cos_idx;
    logic                freq_acc;
    logic                last_tag;
    logic                flush_go;

    // Quarter-wave table: round(127*sin(2*pi*k/64)), k = 0..16; other quadrants by symmetry.
    function automatic logic signed [7:0] sin_lut(input logic [5:0] k);
        logic [4:0]         a;
        logic [6:0]         mag;
        logic signed [7:0]  v;
        a = k[4] ? (5'd16 - {1'b0, k[3:0]}) : {1'b0, k[3:0]};
        case (a)
            5'd0:    mag = 7'd0;
            5'd1:    mag = 7'd12;
            5'd2:    mag = 7'd25;
            5'd3:    mag = 7'd37;
            5'd4:    mag = 7'd49;
            5'd5:    mag = 7'd60;
            5'd6:    mag = 7'd71;
            5'd7:    mag = 7'd81;
            5'd8:    mag = 7'd90;
            5'd9:    mag = 7'd98;
            5'd10:   mag = 7'd106;
            5'd11:   mag = 7'd112;
            5'd12:   mag = 7'd117;
            5'd13:   mag = 7'd122;
            5'd14:   mag = 7'd125;
            5'd15:   mag = 7'd126;
            5'd16:   mag = 7'd127;
            default: mag = 7'd0;
        endcase
        v = {1'b0, mag};
        return k[5] ? -v : v;
    endfunction

    assign sin_idx  = phase_q[PHASE_W-1 -: TABLE_AW];
    assign cos_idx  = sin_idx + TABLE_AW'(16);
    assign freq_acc = bus_io.freq_valid && (state_q == StRun);
    // Tag of the most recent enable, including one on mixer_en right now.
    assign last_tag = mixer_en_q ? en_tag_q : tag_prev_q;
    // A sample accepted alongside the flush also counts as the last real enable.
    assign flush_go = bus_io.flush && (bus_io.rf_valid || last_tag);

    // Sequencer FSM: prime enables, sample/LO issue with phase update, and the flush enable.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= StPrime;
            prime_cnt_q <= '0;
            phase_q     <= '0;
            freq_q      <= '0;
            mixer_en_q  <= 1'b0;
            en_tag_q    <= 1'b0;
            rf_i_q      <= '0;
            rf_q_q      <= '0;
            lo_i_q      <= '0;
            lo_q_q      <= '0;
        end else begin
            mixer_en_q <= 1'b0;
            en_tag_q   <= 1'b0;
            unique case (state_q)
                StPrime: begin
                    if (prime_cnt_q != PrimeEnables) begin
                        mixer_en_q  <= 1'b1;
                        prime_cnt_q <= prime_cnt_q + 2'd1;
                        rf_i_q      <= '0;
                        rf_q_q      <= '0;
                        lo_i_q      <= '0;
                        lo_q_q      <= '0;
                    end else begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (bus_io.rf_valid) begin
                        rf_i_q     <= bus_io.rf_i_in;
                        rf_q_q     <= bus_io.rf_q_in;
                        lo_i_q     <= DW'(sin_lut(cos_idx));
                        lo_q_q     <= DW'(sin_lut(sin_idx));
                        mixer_en_q <= 1'b1;
                        en_tag_q   <= 1'b1;
                    end
                    // A retune wins over the phase step; a colliding sample keeps the old phase.
                    if (freq_acc) begin
                        freq_q  <= bus_io.freq_word;
                        phase_q <= '0;
                    end else if (bus_io.rf_valid) begin
                        phase_q <= phase_q + freq_q;
                    end
                    if (flush_go) begin
                        state_q <= StFlush;
                    end
                end
                StFlush: begin
                    mixer_en_q <= 1'b1;
                    rf_i_q     <= '0;
                    rf_q_q     <= '0;
                    lo_i_q     <= '0;
                    lo_q_q     <= '0;
                    state_q    <= StRun;
                end
                default: state_q <= StPrime;
            endcase
        end
    end

    // Valid tracking: an enable following a real-sample enable pushes a real IF result out.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tag_prev_q <= 1'b0;
            if_valid_q <= 1'b0;
        end else begin
            if_valid_q <= mixer_en_q && tag_prev_q;
            if (mixer_en_q) begin
                tag_prev_q <= en_tag_q;
            end
        end
    end

    assign bus_io.freq_ready = (state_q == StRun);
    assign bus_io.busy       = (state_q != StRun);
    assign bus_io.mixer_en   = mixer_en_q;
    assign bus_io.if_valid   = if_valid_q;
    assign bus_io.rf_i       = rf_i_q;
    assign bus_io.rf_q       = rf_q_q;
    assign bus_io.lo_i       = lo_i_q;
    assign bus_io.lo_q       = lo_q_q;

endmodule

// File: tb/tb_mixer_lo_sequencer.sv
// Bench for mixer_lo_sequencer: cycle-level reference model plus a behavioural two-enable mixer.
module tb_mixer_lo_sequencer;

    localparam int PHASE_W  = 16;
    localparam int TABLE_AW = 6;
    localparam int DW       = 8;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    mixer_lo_sequencer_if #(.PHASE_W(PHASE_W), .DW(DW)) bus ();

    mixer_lo_sequencer #(
        .PHASE_W (PHASE_W),
        .TABLE_AW(TABLE_AW),
        .DW      (DW)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus_io (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Downstream mixer: each enable latches operands and outputs the product of the previous ones.
    int mx_a_i = 5, mx_a_q = 3, mx_b_i = 7, mx_b_q = 11;
    int mx_if_i = 777, mx_if_q = -777;
    always @(posedge clock) begin
        if (bus.mixer_en) begin
            mx_if_i <= mx_a_i * mx_b_i - mx_a_q * mx_b_q;
            mx_if_q <= mx_a_i * mx_b_q + mx_a_q * mx_b_i;
            mx_a_i  <= int'($signed(bus.rf_i));
            mx_a_q  <= int'($signed(bus.rf_q));
            mx_b_i  <= int'($signed(bus.lo_i));
            mx_b_q  <= int'($signed(bus.lo_q));
        end
    end

    function automatic int ref_sin(input int k);
        real v;
        v = 127.0 * $sin(2.0 * 3.14159265358979 * k / 64.0);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    // Reference model state (mode: 0 priming, 1 running, 2 flushing).
    int m_mode, m_pcnt, m_phase, m_freq;
    bit m_prev_tag, m_after_rst;
    bit exp_en, exp_tag, exp_ifv;
    int e_ri, e_rq, e_li, e_lq;
    int pend_i[$];
    int pend_q[$];
    int ifv_seen = 0;
    int last_if_i = 0, last_if_q = 0;

    task automatic model_reset();
        m_mode      = 0;
        m_pcnt      = 0;
        m_phase     = 0;
        m_freq      = 0;
        m_prev_tag  = 1'b0;
        m_after_rst = 1'b1;
        exp_en      = 1'b0;
        exp_tag     = 1'b0;
        exp_ifv     = 1'b0;
        pend_i.delete();
        pend_q.delete();
    endtask

    // One clock: check this cycle's outputs, drive inputs, advance the model, step the clock.
    task automatic tick(input bit rst, input bit rfv, input int ri, input int rq,
                        input bit fv, input int fw, input bit fl);
        int idx;
        bit nxt_en, nxt_tag, last_tag, go_flush;
        check_eq("mixer_en", int'(bus.mixer_en), int'(exp_en));
        if (exp_en) begin
            check_eq("rf_i", int'($signed(bus.rf_i)), e_ri);
            check_eq("rf_q", int'($signed(bus.rf_q)), e_rq);
            check_eq("lo_i", int'($signed(bus.lo_i)), e_li);
            check_eq("lo_q", int'($signed(bus.lo_q)), e_lq);
        end else if (m_after_rst) begin
            check_eq("rst_rf_i", int'(bus.rf_i), 0);
            check_eq("rst_rf_q", int'(bus.rf_q), 0);
            check_eq("rst_lo_i", int'(bus.lo_i), 0);
            check_eq("rst_lo_q", int'(bus.lo_q), 0);
        end
        check_eq("if_valid", int'(bus.if_valid), int'(exp_ifv));
        check_eq("freq_ready", int'(bus.freq_ready), int'(m_mode == 1));
        check_eq("busy", int'(bus.busy), int'(m_mode != 1));
        if (bus.if_valid) begin
            ifv_seen++;
            check_eq("if_pending", int'(pend_i.size() != 0), 1);
            if (pend_i.size() != 0) begin
                check_eq("if_i", mx_if_i, pend_i.pop_front());
                check_eq("if_q", mx_if_q, pend_q.pop_front());
                last_if_i = mx_if_i;
                last_if_q = mx_if_q;
            end
        end

        reset_n         = !rst;
        bus.rf_valid    = rfv;
        bus.rf_i_in     = 8'(ri);
        bus.rf_q_in     = 8'(rq);
        bus.freq_valid  = fv;
        bus.freq_word   = 16'(fw);
        bus.flush       = fl;

        if (rst) begin
            model_reset();
        end else begin
            m_after_rst = 1'b0;
            exp_ifv  = exp_en && m_prev_tag;
            last_tag = exp_en ? exp_tag : m_prev_tag;
            if (exp_en) m_prev_tag = exp_tag;
            nxt_en  = 1'b0;
            nxt_tag = 1'b0;
            case (m_mode)
                0: begin
                    if (m_pcnt < 3) begin
                        nxt_en = 1'b1;
                        m_pcnt++;
                        e_ri = 0; e_rq = 0; e_li = 0; e_lq = 0;
                    end else begin
                        m_mode = 1;
                    end
                end
                1: begin
                    go_flush = fl && (rfv || last_tag);
                    if (rfv) begin
                        idx  = m_phase >> (PHASE_W - TABLE_AW);
                        e_ri = ri;
                        e_rq = rq;
                        e_li = ref_sin((idx + 16) % 64);
                        e_lq = ref_sin(idx);
                        nxt_en  = 1'b1;
                        nxt_tag = 1'b1;
                        pend_i.push_back(e_ri * e_li - e_rq * e_lq);
                        pend_q.push_back(e_ri * e_lq + e_rq * e_li);
                    end
                    if (fv) begin
                        m_freq  = fw;
                        m_phase = 0;
                    end else if (rfv) begin
                        m_phase = (m_phase + m_freq) % 65536;
                    end
                    if (go_flush) m_mode = 2;
                end
                default: begin
                    nxt_en = 1'b1;
                    e_ri = 0; e_rq = 0; e_li = 0; e_lq = 0;
                    m_mode = 1;
                end
            endcase
            exp_en  = nxt_en;
            exp_tag = nxt_tag;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic sample(input int ri, input int rq);
        tick(1'b0, 1'b1, ri, rq, 1'b0, 0, 1'b0);
    endtask

    int busy_cnt, en_cnt, base;

    initial begin
        bus.rf_valid   = 1'b0;
        bus.rf_i_in    = '0;
        bus.rf_q_in    = '0;
        bus.freq_valid = 1'b0;
        bus.freq_word  = '0;
        bus.flush      = 1'b0;
        reset_n        = 1'b0;
        @(posedge clock);
        #1;
        model_reset();
        tick(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);

        // Reset release and prime.
        idle(1);
        busy_cnt = 0;
        en_cnt   = 0;
        for (int i = 0; i < 6; i++) begin
            busy_cnt += int'(bus.busy);
            en_cnt   += int'(bus.mixer_en);
            idle(1);
        end
        check_eq("prime_busy_cycles", busy_cnt, 3);
        check_eq("prime_enables", en_cnt, 3);
        check_eq("prime_if_i", mx_if_i, 0);
        check_eq("prime_if_q", mx_if_q, 0);
        check_eq("prime_no_if_valid", ifv_seen, 0);

        // DC LO.
        base = ifv_seen;
        for (int i = 0; i < 10; i++) sample(64, 0);
        idle(2);
        check_eq("dc_if_valid_count", ifv_seen - base, 9);
        check_eq("dc_if_i", last_if_i, 8128);
        check_eq("dc_if_q", last_if_q, 0);

        // Tone stepping one table entry per sample, through the wrap.
        tick(1'b0, 1'b0, 0, 0, 1'b1, 16'h0400, 1'b0);
        for (int i = 0; i < 66; i++) sample(100, 0);
        idle(1);

        // Retune colliding with a sample.
        tick(1'b0, 1'b1, 100, 0, 1'b1, 16'h0C00, 1'b0);
        for (int i = 0; i < 4; i++) sample(-37, 90);
        idle(1);
        tick(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b1);
        idle(3);

        // Five samples, flush, second flush ignored.
        base = ifv_seen;
        for (int i = 0; i < 5; i++) sample(20 * i - 50, 33 - 7 * i);
        idle(2);
        tick(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b1);
        idle(2);
        tick(1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b1);
        idle(3);
        check_eq("flush_if_valid_count", ifv_seen - base, 5);

        // Reset between samples.
        for (int i = 0; i < 3; i++) sample(55, -12);
        tick(1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0);
        base = ifv_seen;
        idle(6);
        check_eq("rst_no_stale_if_valid", ifv_seen - base, 0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 7),
                 int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128,
                 ($urandom_range(0, 19) == 0),
                 int'($urandom_range(0, 65535)),
                 ($urandom_range(0, 14) == 0));
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
